bus_demultiplexer_4: RTL

- Registered 1-to-4 bus demultiplexer. It is the distribution-side counterpart of the 4-input bus multiplexer.
- Takes one source bus with a valid/ready handshake and steers each accepted word, by Sel, into one of four holding registers.
- Each holding register presents its word to its own consumer under an independent valid/ready handshake.
- Used where one internal data bus must be written into one of four destination latches or registers that consume at their own pace.

---
 rtl/bus_demultiplexer_4.sv | 115 +++++++++++
 1 files changed

// File: rtl/bus_demultiplexer_4.sv
// -----------------------------------------------------------------------------
// bus_demultiplexer_4
//
// Registered 1-to-4 bus demultiplexer. One source bus with a valid/ready
// handshake is steered by Sel into one of four holding registers. Each holding
// register hands its word to its own consumer under an independent valid/ready
// handshake, so the four destinations can consume at their own pace.
//
// Parameters
//   NrOfBits      width of the data bus and of every holding register
//
// Ports
//   Clock         system clock, all state updates on the rising edge
//   Reset         synchronous, active-high reset
//   Enable        block enable; low blocks new accepts, draining continues
//   Sel           destination channel for the current input word
//   DemuxIn       source data word
//   DemuxInValid  source presents a word this cycle
//   DemuxInReady  block accepts the word this cycle (combinational)
//   DemuxOut_0..3 holding-register contents of channel 0..3 (0 when not valid)
//   OutValid      bit k set: channel k holds an undelivered word
//   OutReady      bit k set: consumer k takes channel k's word this cycle
//   Busy          OR of OutValid, derived from registered state only
// -----------------------------------------------------------------------------
module bus_demultiplexer_4 #(
   parameter int unsigned NrOfBits = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Enable,
   input  logic [1:0]          Sel,
   input  logic [NrOfBits-1:0] DemuxIn,
   input  logic                DemuxInValid,
   output logic                DemuxInReady,
   output logic [NrOfBits-1:0] DemuxOut_0,
   output logic [NrOfBits-1:0] DemuxOut_1,
   output logic [NrOfBits-1:0] DemuxOut_2,
   output logic [NrOfBits-1:0] DemuxOut_3,
   output logic [3:0]          OutValid,
   input  logic [3:0]          OutReady,
   output logic                Busy
);

   localparam int unsigned NrOfChannels = 4;

   // Holding registers and their valid flags.
   logic [NrOfBits-1:0] holdQ [NrOfChannels];
   logic [NrOfBits-1:0] holdD [NrOfChannels];
   logic [3:0]          validQ;
   logic [3:0]          validD;

   // Handshake decode.
   logic [3:0] selOneHot;
   logic       chanFree;
   logic       accept;
   logic [3:0] load;
   logic [3:0] drain;

   // ---------------------------------------------------------------------------
   // Input-side handshake
   // ---------------------------------------------------------------------------
   // The addressed channel can take a word if it is empty, or if its consumer
   // takes the current word on this same edge (full-throughput pass-through).
   always_comb begin
      selOneHot    = 4'b0001 << Sel;
      chanFree     = ~validQ[Sel] | OutReady[Sel];
      DemuxInReady = Enable & ~Reset & chanFree;
      accept       = DemuxInValid & DemuxInReady;
      load         = accept ? selOneHot : 4'b0000;
   end

   // ---------------------------------------------------------------------------
   // Output-side handshake and next state
   // ---------------------------------------------------------------------------
   // A load on the same edge as a drain wins, keeping the channel valid with
   // the new word while the old word is delivered.
   always_comb begin
      drain  = validQ & OutReady;
      validD = (validQ & ~drain) | load;
      for (int k = 0; k < NrOfChannels; k++) begin
         holdD[k] = load[k] ? DemuxIn : holdQ[k];
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         validQ <= 4'b0000;
         for (int k = 0; k < NrOfChannels; k++) begin
            holdQ[k] <= '0;
         end
      end else begin
         validQ <= validD;
         for (int k = 0; k < NrOfChannels; k++) begin
            holdQ[k] <= holdD[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Empty channels read as zero; the register itself keeps its last value.
   always_comb begin
      OutValid   = validQ;
      Busy       = |validQ;
      DemuxOut_0 = validQ[0] ? holdQ[0] : '0;
      DemuxOut_1 = validQ[1] ? holdQ[1] : '0;
      DemuxOut_2 = validQ[2] ? holdQ[2] : '0;
      DemuxOut_3 = validQ[3] ? holdQ[3] : '0;
   end

endmodule
